// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: fetch-side bundle in, decode-side bundle out, plus flush/stall/error.
// Latency: n/a (signal bundle only).
// Backpressure: fq_stall toward fetch, dec_ready from decode.
//
// Ports (via modports):
//   master : drives flush, in_*, dec_ready; observes fq_stall, out_*, overflow_err
//   slave  : the queue itself, the mirror image of master

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif

interface fetch_queue_if #(
    parameter int ADDR_W = `INST_ADDR_WIDTH,
    parameter int INST_W = `INST_WIDTH,
    parameter int GHR_W  = `BP_GHR_BITS
);
    // control
    logic              flush;
    logic              fq_stall;
    logic              overflow_err;

    // fetch side, two lanes
    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_pc_0;
    logic [ADDR_W-1:0] in_pc_1;
    logic [INST_W-1:0] in_inst_0;
    logic [INST_W-1:0] in_inst_1;
    logic              in_pred_taken_0;
    logic              in_pred_taken_1;
    logic [ADDR_W-1:0] in_pred_target_0;
    logic [ADDR_W-1:0] in_pred_target_1;
    logic [GHR_W-1:0]  in_pred_hist_0;
    logic [GHR_W-1:0]  in_pred_hist_1;

    // decode side, two lanes
    logic [1:0]        out_valid;
    logic [ADDR_W-1:0] out_pc_0;
    logic [ADDR_W-1:0] out_pc_1;
    logic [INST_W-1:0] out_inst_0;
    logic [INST_W-1:0] out_inst_1;
    logic              out_pred_taken_0;
    logic              out_pred_taken_1;
    logic [ADDR_W-1:0] out_pred_target_0;
    logic [ADDR_W-1:0] out_pred_target_1;
    logic [GHR_W-1:0]  out_pred_hist_0;
    logic [GHR_W-1:0]  out_pred_hist_1;
    logic              dec_ready;

    modport master (
        output flush, in_valid,
        output in_pc_0, in_pc_1, in_inst_0, in_inst_1,
        output in_pred_taken_0, in_pred_taken_1,
        output in_pred_target_0, in_pred_target_1,
        output in_pred_hist_0, in_pred_hist_1,
        output dec_ready,
        input  fq_stall, overflow_err, out_valid,
        input  out_pc_0, out_pc_1, out_inst_0, out_inst_1,
        input  out_pred_taken_0, out_pred_taken_1,
        input  out_pred_target_0, out_pred_target_1,
        input  out_pred_hist_0, out_pred_hist_1
    );

    modport slave (
        input  flush, in_valid,
        input  in_pc_0, in_pc_1, in_inst_0, in_inst_1,
        input  in_pred_taken_0, in_pred_taken_1,
        input  in_pred_target_0, in_pred_target_1,
        input  in_pred_hist_0, in_pred_hist_1,
        input  dec_ready,
        output fq_stall, overflow_err, out_valid,
        output out_pc_0, out_pc_1, out_inst_0, out_inst_1,
        output out_pred_taken_0, out_pred_taken_1,
        output out_pred_target_0, out_pred_target_1,
        output out_pred_hist_0, out_pred_hist_1
    );
endinterface

// File: rtl/fetch_queue.sv
// Two-in/two-out circular instruction queue between fetch and decode.
// Latency: entry written at edge t is visible to decode from cycle t+1 (no bypass).
// Backpressure: fq_stall raised early enough to absorb fetch's in-flight bundle; dec_ready pops.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset; clears pointers, count and overflow_err
//   fq   - fetch_queue_if.slave: fetch bundle in, decode bundle out, flush/stall/error

`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif

module fetch_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = `INST_ADDR_WIDTH,
    parameter int INST_W = `INST_WIDTH,
    parameter int GHR_W  = `BP_GHR_BITS
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              pred_taken;
        logic [ADDR_W-1:0] pred_target;
        logic [GHR_W-1:0]  pred_hist;
    } entry_t;

    // Storage is deliberately left unreset; validity comes from count alone.
    entry_t            mem [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              overflow_q;

    entry_t            lane_in_0;
    entry_t            lane_in_1;
    entry_t            wr_first;
    logic [1:0]        pop_n;
    logic [1:0]        push_n;
    logic [CNT_W:0]    space;
    logic              room_ok;
    logic              accept;
    logic [PTR_W-1:0]  head_p1;
    logic [PTR_W-1:0]  tail_p1;

    // Incoming lanes as packed entries.
    always_comb begin
        lane_in_0 = '{pc:          fq.in_pc_0,
                      inst:        fq.in_inst_0,
                      pred_taken:  fq.in_pred_taken_0,
                      pred_target: fq.in_pred_target_0,
                      pred_hist:   fq.in_pred_hist_0};
        lane_in_1 = '{pc:          fq.in_pc_1,
                      inst:        fq.in_inst_1,
                      pred_taken:  fq.in_pred_taken_1,
                      pred_target: fq.in_pred_target_1,
                      pred_hist:   fq.in_pred_hist_1};
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Decode takes every lane it is shown, so pop count follows out_valid.
    always_comb begin
        pop_n = 2'd0;
        if (fq.dec_ready) begin
            if (count >= CNT_W'(2))
                pop_n = 2'd2;
            else if (count >= CNT_W'(1))
                pop_n = 2'd1;
        end
    end

    assign push_n = {1'b0, fq.in_valid[0]} + {1'b0, fq.in_valid[1]};

    // Free slots this cycle include whatever decode is taking right now, so a
    // full queue can still accept while draining. DEPTH - count never underflows.
    assign space   = (CNT_W+1)'(DEPTH) - {1'b0, count} + (CNT_W+1)'(pop_n);
    assign room_ok = ((CNT_W+1)'(push_n) <= space);
    assign accept  = !fq.flush && room_ok && (push_n != 2'd0);

    // Lanes pack toward tail: a lone lane 1 (mask 10) lands at tail, not tail+1.
    assign wr_first = fq.in_valid[0] ? lane_in_0 : lane_in_1;

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[tail] <= wr_first;
            if (push_n == 2'd2)
                mem[tail_p1] <= lane_in_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else if (fq.flush) begin
            // Flush drops the presented bundle and ignores any pop, but the
            // error flag survives so software can still see it afterwards.
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head + PTR_W'(pop_n);
            if (accept) begin
                tail  <= tail + PTR_W'(push_n);
                count <= count - CNT_W'(pop_n) + CNT_W'(push_n);
            end else begin
                count <= count - CNT_W'(pop_n);
            end
            // An oversized bundle is dropped whole; never a partial write.
            if (!room_ok)
                overflow_q <= 1'b1;
        end
    end

    // Show-ahead outputs straight from registers.
    entry_t lane_out_0;
    entry_t lane_out_1;

    assign lane_out_0 = mem[head];
    assign lane_out_1 = mem[head_p1];

    assign fq.out_valid         = {count >= CNT_W'(2), count >= CNT_W'(1)};
    assign fq.out_pc_0          = lane_out_0.pc;
    assign fq.out_inst_0        = lane_out_0.inst;
    assign fq.out_pred_taken_0  = lane_out_0.pred_taken;
    assign fq.out_pred_target_0 = lane_out_0.pred_target;
    assign fq.out_pred_hist_0   = lane_out_0.pred_hist;
    assign fq.out_pc_1          = lane_out_1.pc;
    assign fq.out_inst_1        = lane_out_1.inst;
    assign fq.out_pred_taken_1  = lane_out_1.pred_taken;
    assign fq.out_pred_target_1 = lane_out_1.pred_target;
    assign fq.out_pred_hist_1   = lane_out_1.pred_hist;

    // Fetch's output register may hold a bundle already, and a stall seen now
    // only blocks the bundle after next; keep room for 2 + 2 with no pops.
    assign fq.fq_stall     = (count > CNT_W'(DEPTH - 4));
    assign fq.overflow_err = overflow_q;

endmodule
